vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers, reused by the timing generator,
// sprite and framebuffer blocks.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned PIPE_DLY_DEF  = 2;

  // Total period of one axis: visible region plus both porches and the sync.
  function automatic int unsigned span_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = span_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = span_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank;
  } sync_bundle_t;

  // Syncs inactive (high) and colour disabled.
  localparam sync_bundle_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth register shift line with synchronous active-low reset to a
// caller-supplied value; depth 0 degenerates to a wire.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_s;
    assign unused_s = ^{clk_i, rst_ni, rst_val_i};
    assign q_o      = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= rst_val_i;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, colour-enable decode, and syncs
// delayed to line up with a ROM-plus-register colour path downstream.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned PIPE_DLY  = PIPE_DLY_DEF
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t       x_q, x_d;
  coord_t       y_q, y_d;
  logic [7:0]   frame_q, frame_d;
  sync_bundle_t raw_s;
  sync_bundle_t dly_s;

  // Raster advance: the line wrap carries into the row, the frame wrap into frame_cnt.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    if (x_q == H_LAST) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d     = 10'd0;
        frame_d = frame_q + 8'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      frame_q <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign blank = (x_q < H_VIS) && (y_q < V_VIS);

  always_comb begin
    raw_s       = SYNC_IDLE;
    raw_s.hs_n  = !((x_q >= HS_START) && (x_q < HS_END));
    raw_s.vs_n  = !((y_q >= VS_START) && (y_q < VS_END));
    raw_s.blank = blank;
  end

  // Reset loads every stage idle, so a sync in flight is cut off at the reset edge.
  delay_line #(
    .WIDTH($bits(sync_bundle_t)),
    .DEPTH(int'(PIPE_DLY))
  ) u_sync_dly (
    .clk_i     (vga_clk),
    .rst_ni    (reset_n),
    .rst_val_i (SYNC_IDLE),
    .d_i       (raw_s),
    .q_o       (dly_s)
  );

  assign hs          = dly_s.hs_n;
  assign vs          = dly_s.vs_n;
  assign blank_d     = dly_s.blank;
  assign line_start  = (x_q == 10'd0);
  assign frame_start = (x_q == 10'd0) && (y_q == 10'd0);
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_cnt   = frame_q;

endmodule
